// File: rtl/inv_chan_filt.sv
// One channel of the filtered inverter bank: two-flop synchroniser, debounce counter,
// accepted-level register and a one-cycle change pulse.
module inv_chan_filt #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter bit          INVERT        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic y,
  output logic edge_p
);

  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            state_q, state_d;
  logic            edge_q, edge_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = a;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    edge_d  = 1'b0;
    // Any cycle where the synchronised level agrees with state discards the run.
    if (sync2_q != state_q) begin
      if (cnt_q == CntLast) begin
        state_d = sync2_q;
        edge_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
    end
  end

  assign y      = state_q ^ INVERT;
  assign edge_p = edge_q;

endmodule

// File: rtl/inv_bank_filt.sv
// N-channel glitch-filtered inverter/buffer bank for noisy or asynchronous CPLD inputs.
// Channels are fully independent copies of inv_chan_filt.
module inv_bank_filt #(
  parameter int unsigned CHANNELS      = 6,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter bit          INVERT        = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] y,
  output logic [CHANNELS-1:0] edge_p
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    inv_chan_filt #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .INVERT       (INVERT)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .a     (a[i]),
      .y     (y[i]),
      .edge_p(edge_p[i])
    );
  end

endmodule

// File: tb/tb_inv_bank_filt.sv
// Bench for inv_bank_filt: default bank (6 ch, depth 4, inverting) plus a 1-channel,
// depth-1, non-inverting instance, both checked against a window-based reference model.
module tb_inv_bank_filt;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] a;
  logic [5:0] y;
  logic [5:0] edge_p;
  logic [0:0] a1;
  logic [0:0] y1;
  logic [0:0] e1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inv_bank_filt u_dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .y     (y),
    .edge_p(edge_p)
  );

  inv_bank_filt #(
    .CHANNELS     (1),
    .FILTER_CYCLES(1),
    .INVERT       (1'b0)
  ) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .a     (a1),
    .y     (y1),
    .edge_p(e1)
  );

  // Model bits 0..5 are the default bank, bit 6 is the single-channel instance.
  logic [6:0] m_state = '0;
  logic [6:0] m_edge  = '0;
  logic [6:0] aq[$];
  logic [6:0] hist[$];
  int         since[7];

  function automatic int fc_of(int i);
    return (i < 6) ? 4 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // A level is accepted once the synchronised input has disagreed with the accepted
  // level on FILTER_CYCLES consecutive edges since the last acceptance or reset.
  task automatic model_edge();
    logic [6:0] av;
    logic [6:0] s2;
    bit         all_diff;
    int         n;
    av     = {a1, a};
    m_edge = '0;
    if (rst) begin
      m_state = '0;
      aq.delete();
      aq.push_back(7'd0);
      aq.push_back(7'd0);
      hist.delete();
      for (int i = 0; i < 7; i++) since[i] = 0;
    end else begin
      s2 = aq.pop_front();
      aq.push_back(av);
      hist.push_back(s2);
      if (hist.size() > 8) void'(hist.pop_front());
      n = hist.size();
      for (int i = 0; i < 7; i++) begin
        since[i]++;
        if (since[i] >= fc_of(i)) begin
          all_diff = 1'b1;
          for (int k = 1; k <= fc_of(i); k++) begin
            if (hist[n-k][i] == m_state[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_state[i] = ~m_state[i];
            m_edge[i]  = 1'b1;
            since[i]   = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    logic [6:0] exp_y;
    @(posedge clk);
    model_edge();
    #1;
    exp_y = m_state ^ 7'b0111111;
    check_eq("y", {26'd0, y}, {26'd0, exp_y[5:0]});
    check_eq("edge_p", {26'd0, edge_p}, {26'd0, m_edge[5:0]});
    check_eq("y1", {31'd0, y1}, {31'd0, exp_y[6]});
    check_eq("edge_p1", {31'd0, e1}, {31'd0, m_edge[6]});
  endtask

  task automatic run(input logic [5:0] av, input logic av1, input int cycles);
    a  = av;
    a1 = av1;
    for (int c = 0; c < cycles; c++) tick();
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    a1  = '0;
    run(6'h00, 1'b0, 2);
    check_eq("reset_y", {26'd0, y}, 32'h3F);
    check_eq("reset_y1", {31'd0, y1}, 32'h0);
    rst = 1'b0;

    // Single-channel accept; y[0] falls after the fifth edge from capture.
    run(6'h01, 1'b1, 5);
    check_eq("accept_pre", {26'd0, y}, 32'h3F);
    run(6'h01, 1'b1, 1);
    check_eq("accept_y", {26'd0, y}, 32'h3E);
    check_eq("accept_edge", {26'd0, edge_p}, 32'h01);
    run(6'h01, 1'b1, 4);

    // Glitch shorter than the filter depth, then one exactly as long.
    run(6'h03, 1'b0, 3);
    run(6'h01, 1'b0, 8);
    check_eq("glitch3_y", {26'd0, y}, 32'h3E);
    run(6'h03, 1'b0, 4);
    run(6'h01, 1'b0, 12);

    // Parallel transitions.
    run(6'h2A, 1'b1, 10);
    run(6'h00, 1'b0, 10);
    check_eq("parallel_back", {26'd0, y}, 32'h3F);

    // Chatter on a[2].
    for (int c = 0; c < 50; c++) run((c % 2 == 0) ? 6'h04 : 6'h00, 1'b0, 1);
    run(6'h00, 1'b0, 4);

    // Reset mid-count; the count restarts after release.
    run(6'h3F, 1'b0, 4);
    rst = 1'b1;
    run(6'h3F, 1'b0, 1);
    check_eq("midcnt_reset_y", {26'd0, y}, 32'h3F);
    rst = 1'b0;
    run(6'h3F, 1'b0, 8);
    run(6'h00, 1'b0, 8);

    // One-cycle pulse through the depth-1 channel.
    run(6'h00, 1'b1, 1);
    run(6'h00, 1'b0, 5);

    // Random levels with random hold times and occasional resets.
    for (int r = 0; r < 200; r++) begin
      rst = ($urandom_range(0, 40) == 0);
      run(6'($urandom), 1'($urandom), $urandom_range(1, 6));
    end
    rst = 1'b0;
    run(6'h00, 1'b0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
